// File: rtl/ysyx_22050710_data_sram_resp_pkg.sv
// Shared constants and helpers for the data-side SRAM responder.
package ysyx_22050710_mem_pkg;

  localparam int unsigned DSRAM_ADDR_WD     = 32;
  localparam int unsigned DSRAM_DATA_WD     = 64;
  localparam int unsigned DSRAM_LANES       = 8;
  localparam int unsigned DSRAM_DEPTH_WORDS = 4096;
  localparam logic [DSRAM_ADDR_WD-1:0] DSRAM_BASE_ADDR = 32'h8000_0000;

  // True when base <= addr < base + span; one extra bit keeps the limit from wrapping.
  function automatic logic dsram_in_range(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input logic [63:0] span);
    logic [64:0] limit;
    limit = 65'(base) + 65'(span);
    return (addr >= base) && (65'(addr) < limit);
  endfunction

  // Replace the byte lanes of old_word selected by mask with the lanes of new_word.
  function automatic logic [DSRAM_DATA_WD-1:0] dsram_byte_merge(
      input logic [DSRAM_DATA_WD-1:0] old_word,
      input logic [DSRAM_DATA_WD-1:0] new_word,
      input logic [DSRAM_LANES-1:0]   mask);
    logic [DSRAM_DATA_WD-1:0] merged;
    merged = old_word;
    for (int k = 0; k < int'(DSRAM_LANES); k++) begin
      if (mask[k]) merged[k*8 +: 8] = new_word[k*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ysyx_22050710_data_sram_resp_if.sv
// Data SRAM request/response bundle between the execute stage and the responder.
interface ysyx_22050710_data_sram_resp_if #(
  parameter int unsigned SRAM_ADDR_WD  = 32,
  parameter int unsigned SRAM_DATA_WD  = 64,
  parameter int unsigned SRAM_WMASK_WD = 8
);
  logic [SRAM_ADDR_WD-1:0]  addr;
  logic                     ren;
  logic                     wen;
  logic [SRAM_WMASK_WD-1:0] wmask;
  logic [SRAM_DATA_WD-1:0]  wdata;
  logic [SRAM_DATA_WD-1:0]  rdata;
  logic                     rvalid;
  logic                     err;

  modport master (output addr, ren, wen, wmask, wdata,
                  input  rdata, rvalid, err);
  modport slave  (input  addr, ren, wen, wmask, wdata,
                  output rdata, rvalid, err);
endinterface

// File: rtl/ysyx_22050710_sram_array.sv
// Plain storage: registered read port, byte-masked write port, contents never cleared.
module ysyx_22050710_sram_array
  import ysyx_22050710_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = DSRAM_DEPTH_WORDS,
  localparam int unsigned IDX_WD = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     rd_clr,
  input  logic [IDX_WD-1:0]        rd_idx,
  output logic [DSRAM_DATA_WD-1:0] rdata,
  input  logic                     wr_en,
  input  logic [IDX_WD-1:0]        wr_idx,
  input  logic [DSRAM_LANES-1:0]   wr_mask,
  input  logic [DSRAM_DATA_WD-1:0] wr_data
);

  logic [DSRAM_DATA_WD-1:0] mem [DEPTH];

  // Byte-masked write; a zero mask leaves the word untouched.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= dsram_byte_merge(mem[wr_idx], wr_data, wr_mask);
  end

  // Registered read samples the pre-write word, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (rst || rd_clr) rdata <= '0;
    else if (rd_en)    rdata <= mem[rd_idx];
  end

endmodule

// File: rtl/ysyx_22050710_data_sram_resp.sv
// Data-side SRAM responder: range check, access gating, rvalid/err generation.
// Optional performance counters are built when YSYX_22050710_DSRAM_PERF_EN is defined.
module ysyx_22050710_data_sram_resp
  import ysyx_22050710_mem_pkg::*;
#(
  parameter int unsigned            SRAM_ADDR_WD  = DSRAM_ADDR_WD,
  parameter int unsigned            SRAM_DATA_WD  = DSRAM_DATA_WD,
  parameter int unsigned            SRAM_WMASK_WD = DSRAM_LANES,
  parameter int unsigned            DEPTH_WORDS   = DSRAM_DEPTH_WORDS,
  parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR    = DSRAM_BASE_ADDR
) (
  input  logic i_clk,
  input  logic i_rst,
  ysyx_22050710_data_sram_resp_if.slave bus
`ifdef YSYX_22050710_DSRAM_PERF_EN
  ,
  output logic [63:0] o_perf_rd_cnt,
  output logic [63:0] o_perf_wr_cnt,
  output logic [31:0] o_perf_err_cnt
`endif
);

  localparam int unsigned LANE_SH = $clog2(SRAM_WMASK_WD);
  localparam int unsigned IDX_WD  = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN    = 64'(DEPTH_WORDS) * 64'(SRAM_WMASK_WD);

  logic              in_range_c;
  logic [IDX_WD-1:0] idx_c;
  logic              rd_ok_c;
  logic              wr_ok_c;
  logic              fault_c;

  // Decode the request; address low bits are dropped since lanes come from wmask.
  always_comb begin
    in_range_c = dsram_in_range(64'(bus.addr), 64'(BASE_ADDR), SPAN);
    idx_c      = IDX_WD'((bus.addr - BASE_ADDR) >> LANE_SH);
    rd_ok_c    = bus.ren && in_range_c && !i_rst;
    wr_ok_c    = bus.wen && in_range_c && !i_rst;
    fault_c    = (bus.ren || bus.wen) && !in_range_c && !i_rst;
  end

  ysyx_22050710_sram_array #(
    .DEPTH (DEPTH_WORDS)
  ) u_array (
    .clk     (i_clk),
    .rst     (i_rst),
    .rd_en   (rd_ok_c),
    .rd_clr  (bus.ren && !in_range_c),
    .rd_idx  (idx_c),
    .rdata   (bus.rdata),
    .wr_en   (wr_ok_c),
    .wr_idx  (idx_c),
    .wr_mask (bus.wmask),
    .wr_data (bus.wdata)
  );

  // One-cycle status flags for the request issued in the previous cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      bus.rvalid <= rd_ok_c;
      bus.err    <= fault_c;
    end
  end

`ifdef YSYX_22050710_DSRAM_PERF_EN
  // Free-running event counters, wrapping at their natural width.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_perf_rd_cnt  <= '0;
      o_perf_wr_cnt  <= '0;
      o_perf_err_cnt <= '0;
    end else begin
      if (rd_ok_c)                       o_perf_rd_cnt  <= o_perf_rd_cnt + 64'd1;
      if (wr_ok_c && (bus.wmask != '0))  o_perf_wr_cnt  <= o_perf_wr_cnt + 64'd1;
      if (fault_c)                       o_perf_err_cnt <= o_perf_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050710_data_sram_resp.sv
// Bench for the data SRAM responder: vector table feeding a scoreboard queue.
module tb_ysyx_22050710_data_sram_resp;

  typedef struct {
    logic        rst;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] e_rdata;
    logic        e_rvalid;
    logic        e_err;
  } vec_t;

  typedef struct {
    int          id;
    logic [63:0] rdata;
    logic        rvalid;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  vec_t vecs[$];
  exp_t sb[$];

  ysyx_22050710_data_sram_resp_if bus ();

`ifdef YSYX_22050710_DSRAM_PERF_EN
  logic [63:0] perf_rd;
  logic [63:0] perf_wr;
  logic [31:0] perf_err;
`endif

  ysyx_22050710_data_sram_resp dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef YSYX_22050710_DSRAM_PERF_EN
    ,
    .o_perf_rd_cnt  (perf_rd),
    .o_perf_wr_cnt  (perf_wr),
    .o_perf_err_cnt (perf_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int id, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, got, want);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                              input logic [7:0] m, input logic [63:0] d,
                              input logic [63:0] er, input logic ev, input logic ee);
    vec_t v;
    v.rst = r; v.ren = rd; v.wen = wr; v.addr = a; v.wmask = m; v.wdata = d;
    v.e_rdata = er; v.e_rvalid = ev; v.e_err = ee;
    return v;
  endfunction

  task automatic drive(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [7:0] m, input logic [63:0] d);
    rst = r; bus.ren = rd; bus.wen = wr; bus.addr = a; bus.wmask = m; bus.wdata = d;
  endtask

  // Drive one vector, queue its expectation, then compare once the response cycle has passed.
  task automatic apply(input int id, input vec_t v);
    exp_t e;
    exp_t got;
    drive(v.rst, v.ren, v.wen, v.addr, v.wmask, v.wdata);
    e.id = id; e.rdata = v.e_rdata; e.rvalid = v.e_rvalid; e.err = v.e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard step %0d: queue empty", id);
    end else begin
      got = sb.pop_front();
      check("rdata",  got.id, bus.rdata,        got.rdata);
      check("rvalid", got.id, 64'(bus.rvalid),  64'(got.rvalid));
      check("err",    got.id, 64'(bus.err),     64'(got.err));
    end
  endtask

  localparam logic [63:0] W0   = 64'h1122_3344_5566_7788;
  localparam logic [63:0] W0P  = 64'h1122_3344_BBBB_BBBB;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TOPW = 64'h0123_4567_89AB_CDEF;

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 64'h0);

    //            rst  ren  wen  addr           wmask  wdata                   exp rdata  rv   err
    vecs.push_back(mk(1, 0, 0, 32'h8000_0000, 8'h00, 64'h0,                  64'h0,    0,   0));
    vecs.push_back(mk(1, 0, 0, 32'h8000_0000, 8'h00, 64'h0,                  64'h0,    0,   0));
    vecs.push_back(mk(0, 0, 1, 32'h8000_0000, 8'hFF, W0,                     64'h0,    0,   0));
    vecs.push_back(mk(0, 1, 0, 32'h8000_0000, 8'h00, 64'h0,                  W0,       1,   0));
    vecs.push_back(mk(0, 0, 1, 32'h8000_0000, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, W0,      0,   0));
    vecs.push_back(mk(0, 1, 0, 32'h8000_0000, 8'h00, 64'h0,                  W0P,      1,   0));
    vecs.push_back(mk(0, 0, 1, 32'h8000_0008, 8'hFF, 64'h0,                  W0P,      0,   0));
    vecs.push_back(mk(0, 1, 1, 32'h8000_0008, 8'hFF, ONES,                   64'h0,    1,   0));
    vecs.push_back(mk(0, 1, 0, 32'h8000_0008, 8'h00, 64'h0,                  ONES,     1,   0));
    vecs.push_back(mk(0, 1, 0, 32'h7FFF_FFF8, 8'h00, 64'h0,                  64'h0,    0,   1));
    vecs.push_back(mk(0, 0, 1, 32'h8000_8000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,   0,   1));
    vecs.push_back(mk(0, 0, 0, 32'h8000_0000, 8'h00, 64'h0,                  64'h0,    0,   0));
    vecs.push_back(mk(0, 1, 0, 32'h8000_0000, 8'h00, 64'h0,                  W0P,      1,   0));
    vecs.push_back(mk(0, 0, 1, 32'h8000_7FF8, 8'hFF, TOPW,                   W0P,      0,   0));
    vecs.push_back(mk(0, 1, 0, 32'h8000_7FF8, 8'h00, 64'h0,                  TOPW,     1,   0));
    vecs.push_back(mk(0, 0, 1, 32'h8000_0010, 8'hFF, 64'hA5,                 TOPW,     0,   0));
    vecs.push_back(mk(1, 0, 1, 32'h8000_0010, 8'hFF, 64'h5A,                 64'h0,    0,   0));
    vecs.push_back(mk(1, 1, 0, 32'h8000_0010, 8'h00, 64'h0,                  64'h0,    0,   0));
    vecs.push_back(mk(0, 1, 0, 32'h8000_0010, 8'h00, 64'h0,                  64'hA5,   1,   0));
    vecs.push_back(mk(0, 0, 1, 32'h8000_0000, 8'h00, ONES,                   64'hA5,   0,   0));
    vecs.push_back(mk(0, 1, 0, 32'h8000_0000, 8'h00, 64'h0,                  W0P,      1,   0));
    vecs.push_back(mk(0, 1, 0, 32'h8000_0005, 8'h00, 64'h0,                  W0P,      1,   0));
    vecs.push_back(mk(0, 1, 0, 32'h8000_0008, 8'h00, 64'h0,                  ONES,     1,   0));
    vecs.push_back(mk(0, 0, 0, 32'h8000_0008, 8'h00, 64'h0,                  ONES,     0,   0));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Hand sequence: an out-of-range read and write in one cycle is a single fault.
    apply(100, mk(0, 1, 1, 32'h9000_0000, 8'hFF, ONES, 64'h0, 0, 1));
    apply(101, mk(0, 1, 0, 32'h8000_0008, 8'h00, 64'h0, ONES, 1, 0));

`ifdef YSYX_22050710_DSRAM_PERF_EN
    // Counter sequence: 3 reads, 2 writes (one empty mask), 1 faulting read.
    apply(200, mk(1, 0, 0, 32'h8000_0000, 8'h00, 64'h0, 64'h0, 0, 0));
    check("perf_rd_rst",  200, perf_rd,        64'd0);
    check("perf_wr_rst",  200, perf_wr,        64'd0);
    check("perf_err_rst", 200, 64'(perf_err),  64'd0);
    apply(201, mk(0, 1, 0, 32'h8000_0000, 8'h00, 64'h0, W0P,   1, 0));
    apply(202, mk(0, 1, 0, 32'h8000_0008, 8'h00, 64'h0, ONES,  1, 0));
    apply(203, mk(0, 1, 0, 32'h8000_0010, 8'h00, 64'h0, 64'hA5, 1, 0));
    apply(204, mk(0, 0, 1, 32'h8000_0018, 8'hFF, 64'h77, 64'hA5, 0, 0));
    apply(205, mk(0, 0, 1, 32'h8000_0018, 8'h00, 64'h99, 64'hA5, 0, 0));
    apply(206, mk(0, 1, 0, 32'h0000_0000, 8'h00, 64'h0, 64'h0, 0, 1));
    apply(207, mk(0, 0, 0, 32'h8000_0000, 8'h00, 64'h0, 64'h0, 0, 0));
    check("perf_rd",  207, perf_rd,       64'd3);
    check("perf_wr",  207, perf_wr,       64'd1);
    check("perf_err", 207, 64'(perf_err), 64'd1);
    apply(208, mk(1, 0, 0, 32'h8000_0000, 8'h00, 64'h0, 64'h0, 0, 0));
    check("perf_rd_clr",  208, perf_rd,       64'd0);
    check("perf_wr_clr",  208, perf_wr,       64'd0);
    check("perf_err_clr", 208, 64'(perf_err), 64'd0);
`endif

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_data_sram_resp.md
Name: ysyx_22050710_data_sram_resp

Overview:
Data-side SRAM responder. It is the memory end of the data SRAM interface that the execute stage drives: addr, ren, wen, wmask and wdata. It holds a byte-masked 64-bit memory array. Reads return one cycle later, aligned with the MEM stage. Writes commit at the clock edge of the request cycle, and out-of-range accesses are flagged.

Parameters:
SRAM_ADDR_WD, 32, request address width
SRAM_DATA_WD, 64, data width; must equal 8*SRAM_WMASK_WD
SRAM_WMASK_WD, 8, byte-enable width
DEPTH_WORDS, 4096, number of SRAM_DATA_WD-bit words; power of two
BASE_ADDR, 32'h8000_0000, byte address of word 0

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_data_sram_addr  in  SRAM_ADDR_WD  byte address of the request
i_data_sram_ren  in  1  read request, 1-cycle pulse per read
i_data_sram_wen  in  1  write request
i_data_sram_wmask  in  SRAM_WMASK_WD  byte enables, already lane-shifted
i_data_sram_wdata  in  SRAM_DATA_WD  write data, already lane-shifted
o_data_sram_rdata  out  SRAM_DATA_WD  read data for the previous cycle's read
o_data_sram_rvalid  out  1  rdata corresponds to a successful read issued last cycle
o_data_sram_err  out  1  last cycle's request was out of range

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous, active-high.
- Reset values: rdata=0, rvalid=0, err=0. Array contents are not cleared.
- Index: idx = (addr - BASE_ADDR) >> log2(SRAM_WMASK_WD). addr[2:0] is ignored; lane selection is carried by wmask.
- In range: BASE_ADDR <= addr < BASE_ADDR + DEPTH_WORDS*SRAM_WMASK_WD. Compute in SRAM_ADDR_WD+1 bits so there is no wrap.
- Write: at the edge where wen=1, in range and i_rst=0:
  - byte lane k is updated iff wmask[k];
  - wmask=0 is a legal no-op.
- Read, latency 1:
  - at the edge where ren=1 and in range, rdata <= mem[idx] and rvalid <= 1;
  - if ren=0, rdata holds its previous value and rvalid <= 0.
- Same-cycle ren and wen on the same idx: read-before-write. rdata returns the pre-write word; a read in the next cycle sees the new bytes.
- Back-to-back reads every cycle are supported at full throughput. There is no ready or back-pressure.
- Out of range:
  - write is dropped and err <= 1 next cycle;
  - read sets rdata <= 0, rvalid <= 0, err <= 1.
  - err is a one-cycle pulse per faulting request and is 0 when no request is made.
- Reset asserted mid-operation:
  - a write in the reset cycle is dropped;
  - a read in the reset cycle produces rvalid=0 and rdata=0 next cycle.

Optional Feature:
Macro: YSYX_22050710_DSRAM_PERF_EN.
- When defined, adds three outputs:
  - o_perf_rd_cnt, 64 bits: counts accepted reads;
  - o_perf_wr_cnt, 64 bits: counts accepted writes with nonzero wmask;
  - o_perf_err_cnt, 32 bits: counts faulting requests.
- All counters clear on i_rst, increment at the same edge as the access, and wrap modulo 2^width.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package ysyx_22050710_mem_pkg holds:
  - DSRAM_BASE_ADDR;
  - DSRAM_DEPTH_WORDS;
  - the byte-lane count constant;
  - the in-range check function;
  - the byte-merge function (old, new, mask -> merged).
- Sub-module ysyx_22050710_sram_array: a pure storage array with a registered read port and a byte-masked write port.
- The top level adds range checking, gating, err/rvalid generation and the perf counters.

Test Plan:
1. Write addr=0x8000_0000, wmask=0xFF, wdata=0x1122334455667788; next cycle ren at the same addr -> the cycle after, rdata=0x1122334455667788, rvalid=1, err=0.
2. Partial write wmask=0x0F, wdata=0xAAAAAAAA_BBBBBBBB to the same word, then read -> rdata=0x11223344_BBBBBBBB.
3. Same-cycle ren+wen to 0x8000_0008: old word 0x0, wdata=0xFFFF_FFFF_FFFF_FFFF, wmask=0xFF -> rdata=0x0; a read the following cycle returns all-ones.
4. Read addr=0x7FFF_FFF8, then write addr=BASE+DEPTH*8 -> err pulses 1 on each of the next cycles, rvalid=0, rdata=0, memory unchanged on re-read.
5. Assert i_rst in the same cycle as wen to 0x8000_0010 with wdata=0x5A -> after reset, a read returns the prior contents; rdata, rvalid and err read 0 during and right after reset.
6. With PERF_EN: 3 reads, 2 writes (one with wmask=0), 1 out-of-range read -> rd_cnt=3, wr_cnt=1, err_cnt=1; i_rst clears all three.
